// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control unit for the multicycle MIPS core. A Moore main FSM walks each
// instruction through FETCH/DECODE/... and a combinational ALU decoder turns
// the FSM's ALU request (add / sub / funct) into the 3-bit alucontrol code.
// pcEn is the only output that also depends on a datapath flag (zero).
//
// Ports:
//   clk        in   system clock, rising-edge state updates
//   reset      in   synchronous active-low reset
//   op, funct  in   instr[31:26] / instr[5:0] from the instruction register
//   zero       in   ALU zero flag
//   pcEn       out  PC enable = pcwrite | (branch & zero)
//   IorD       out  memory address select (0 pc, 1 aluout)
//   memwrite   out  memory write strobe
//   IRwrite    out  instruction register load enable
//   regdst     out  write register select (0 rt, 1 rd)
//   memtoreg   out  writeback select (0 aluout, 1 data)
//   regwrite   out  register file write enable
//   alusrcA    out  ALU A select (0 pc, 1 regA)
//   alusrcB    out  ALU B select (00 regB, 01 4, 10 signimm, 11 signimm<<2)
//   pcsrc      out  next-PC select (00 aluresult, 01 aluout, 10 jump target)
//   alucontrol out  ALU operation
//   illegal    out  pulse in DECODE for an unsupported op or R-type funct
//   state      out  current FSM state
module multicycle_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       IorD,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0] next_state;
  logic [3:0] dec_state;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;

  function automatic logic op_supported(input logic [5:0] o);
    return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) ||
           (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
  endfunction

  function automatic logic funct_supported(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  // Unsupported functs fall back to add so the instruction still completes.
  function automatic logic [2:0] alu_decode(input logic [1:0] a, input logic [5:0] f);
    logic [2:0] r;
    case (a)
      ALUOP_SUB: r = 3'b110;
      ALUOP_FUNCT: begin
        case (f)
          6'b100000: r = 3'b010;
          6'b100010: r = 3'b110;
          6'b100100: r = 3'b000;
          6'b100101: r = 3'b001;
          6'b101010: r = 3'b111;
          default:   r = 3'b010;
        endcase
      end
      default: r = 3'b010;
    endcase
    return r;
  endfunction

  // State register: synchronous active-low reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; unused codes 12-15 recover to FETCH.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW:    next_state = MEMADR;
          OP_SW:    next_state = MEMADR;
          OP_RTYPE: next_state = EXECUTE;
          OP_BEQ:   next_state = BRANCH;
          OP_ADDI:  next_state = ADDIEXEC;
          OP_J:     next_state = JUMP;
          default:  next_state = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_SW) begin
          next_state = MEMWR;
        end else begin
          next_state = MEMRD;
        end
      end
      MEMRD:    next_state = MEMWB;
      EXECUTE:  next_state = ALUWB;
      ADDIEXEC: next_state = ADDIWB;
      default:  next_state = FETCH;
    endcase
  end

  // While reset is held the outputs decode as FETCH, so an abandoned
  // instruction cannot leak its selects or strobes into the reset cycle.
  assign dec_state = reset ? state : FETCH;

  // Moore output decode plus write-enable gating during reset.
  always_comb begin
    IorD     = 1'b0;
    memwrite = 1'b0;
    IRwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrcA  = 1'b0;
    alusrcB  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (dec_state)
      FETCH: begin
        IRwrite = 1'b1;
        alusrcB = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcB = 2'b11;
        illegal = !op_supported(op) || ((op == OP_RTYPE) && !funct_supported(funct));
      end
      MEMADR, ADDIEXEC: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      BRANCH: begin
        alusrcA = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
        aluop = ALUOP_ADD;
      end
    endcase
    IRwrite    = IRwrite & reset;
    memwrite   = memwrite & reset;
    regwrite   = regwrite & reset;
    pcwrite    = pcwrite & reset;
    branch     = branch & reset;
    illegal    = illegal & reset;
    alucontrol = alu_decode(aluop, funct);
  end

  assign pcEn = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef logic [19:0] vec_t;
  typedef struct {
    vec_t  v;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA, illegal;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcEn(pcEn), .IorD(IorD), .memwrite(memwrite), .IRwrite(IRwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrcA(alusrcA), .alusrcB(alusrcB), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Expected output vector: {state, pcEn, IorD, memwrite, IRwrite, regdst,
  // memtoreg, regwrite, alusrcA, alusrcB, pcsrc, alucontrol, illegal}
  function automatic vec_t mk(input logic [3:0] st, input logic pe, io, mw, irw, rd, m2r, rw, sa,
                              input logic [1:0] sb, ps, input logic [2:0] ac, input logic il);
    return {st, pe, io, mw, irw, rd, m2r, rw, sa, sb, ps, ac, il};
  endfunction

  function automatic logic op_ok(input logic [5:0] o);
    return o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // ALU code an R-type should request, straight from the funct table.
  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    if (f == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      vec_t got;
      e   = exp_q.pop_front();
      got = {state, pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
             alusrcA, alusrcB, pcsrc, alucontrol, illegal};
      n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %05h (state=%0d) want %05h (state=%0d)",
                 e.name, got, got[19:16], e.v, e.v[19:16]);
      end
    end
  end

  // One clock cycle of stimulus together with the outputs expected in it.
  task automatic step(input logic rst, input logic [5:0] o, f, input logic z,
                      input vec_t v, input string name);
    exp_t e;
    reset = rst;
    op    = o;
    funct = f;
    zero  = z;
    e.v   = v;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Whole instruction from FETCH until return to FETCH. zsel: 0/1 forces the
  // zero flag in the BRANCH cycle, anything else randomises it.
  task automatic run_instr(input logic [5:0] o, f, input int zsel, input string name);
    logic z;
    logic ill;
    // op/funct are garbage during FETCH; they must not matter there.
    step(1'b1, 6'($urandom), 6'($urandom), 1'($urandom),
         mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0),
         {name, "/fetch"});
    ill = !op_ok(o) || ((o == OP_RTYPE) && !funct_ok(f));
    step(1'b1, o, f, 1'($urandom),
         mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b010, ill),
         {name, "/decode"});
    if (o == OP_LW || o == OP_SW) begin
      step(1'b1, o, f, 1'($urandom),
           mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0),
           {name, "/memadr"});
      if (o == OP_LW) begin
        step(1'b1, o, f, 1'($urandom),
             mk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0),
             {name, "/memrd"});
        step(1'b1, o, f, 1'($urandom),
             mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0),
             {name, "/memwb"});
      end else begin
        step(1'b1, o, f, 1'($urandom),
             mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0),
             {name, "/memwr"});
      end
    end else if (o == OP_RTYPE) begin
      step(1'b1, o, f, 1'($urandom),
           mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, rtype_alu(f), 1'b0),
           {name, "/execute"});
      step(1'b1, o, f, 1'($urandom),
           mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0),
           {name, "/aluwb"});
    end else if (o == OP_BEQ) begin
      z = (zsel == 0) ? 1'b0 : (zsel == 1) ? 1'b1 : 1'($urandom);
      step(1'b1, o, f, z,
           mk(4'd8, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 3'b110, 1'b0),
           {name, "/branch"});
    end else if (o == OP_ADDI) begin
      step(1'b1, o, f, 1'($urandom),
           mk(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0),
           {name, "/addiexec"});
      step(1'b1, o, f, 1'($urandom),
           mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0),
           {name, "/addiwb"});
    end else if (o == OP_J) begin
      step(1'b1, o, f, 1'($urandom),
           mk(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'b010, 1'b0),
           {name, "/jump"});
    end else begin
      // unsupported op: DECODE goes straight back to FETCH
    end
  endtask

  // Outputs while reset is held low: FETCH selects, every write enable off.
  function automatic vec_t rst_vec(input logic [3:0] st);
    return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0);
  endfunction

  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] o, f;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b0;
    op    = OP_SW;
    funct = 6'b000000;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, OP_SW, 6'b000000, 1'b0, rst_vec(4'd0), "reset_hold");

    // Directed cases
    run_instr(OP_LW, 6'b000000, 2, "lw");
    run_instr(OP_RTYPE, 6'b101010, 2, "slt");
    run_instr(OP_BEQ, 6'b000000, 1, "beq_taken");
    run_instr(OP_BEQ, 6'b000000, 0, "beq_not_taken");
    run_instr(OP_J, 6'b000000, 2, "j");
    run_instr(OP_SW, 6'b000000, 2, "sw");
    run_instr(OP_ADDI, 6'b000000, 2, "addi");
    run_instr(6'b111111, 6'b000000, 2, "illegal_op");
    run_instr(OP_RTYPE, 6'b000111, 2, "illegal_funct");

    // Reset arriving in MEMWR: write strobe must vanish in that same cycle.
    step(1'b1, OP_LW, 6'b000000, 1'b0,
         mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0),
         "rst_mid/fetch");
    step(1'b1, OP_SW, 6'b000000, 1'b0,
         mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b010, 1'b0),
         "rst_mid/decode");
    step(1'b1, OP_SW, 6'b000000, 1'b0,
         mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0),
         "rst_mid/memadr");
    step(1'b0, OP_SW, 6'b000000, 1'b1, rst_vec(4'd5), "rst_mid/memwr");
    run_instr(OP_J, 6'b000000, 2, "after_rst");

    // Randomised instruction stream
    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 6);
      if (k == 6) begin
        do o = 6'($urandom); while (op_ok(o));
      end else begin
        o = ops[k];
      end
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = fns[$urandom_range(0, 4)];
      run_instr(o, f, 2, "rand");
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
